u_dmem_arbiter: RTL and testbench

U_DMEM_ARBITER -- requirements
Module: u_dmem_arbiter

---
 rtl/u_dmem_arbiter_pkg.sv | 27 ++
 rtl/u_dmem_arb_starve.sv | 45 ++++
 rtl/u_dmem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_u_dmem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/u_dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// u_dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter slice.
//   arb_state_t        : arbiter FSM states (ARB = normal arbitration,
//                        LOCK1 = port 1 holds the memory for a locked burst)
//   P0 / P1            : port-id values carried on the response rid output
//   STARVE_MAX_DEFAULT : default number of denied conflict cycles before
//                        port 1 is forced a grant
// ---------------------------------------------------------------------------
package u_dmem_arbiter_pkg;

   typedef enum logic {
      ARB   = 1'b0,
      LOCK1 = 1'b1
   } arb_state_t;

   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;

   localparam int STARVE_MAX_DEFAULT = 3;

   // Width of a counter that must be able to hold the value max_val.
   function automatic int starve_cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/u_dmem_arb_starve.sv
// ---------------------------------------------------------------------------
// u_dmem_arb_starve
// Saturating starvation counter for port 1 of the data-memory arbiter.
// Counts conflict cycles in which port 0 won, and flags when the count has
// reached STARVE_MAX so the arbiter can hand the next conflict to port 1.
//
// Ports
//   i_sys_clock    in  1  clock, rising edge
//   i_sys_reset_n  in  1  synchronous active-low reset
//   inc            in  1  a conflict cycle was won by port 0
//   clr            in  1  port 1 was granted (clear has priority over inc)
//   at_max         out 1  counter equals STARVE_MAX
// ---------------------------------------------------------------------------
module u_dmem_arb_starve
   import u_dmem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic i_sys_clock,
   input  logic i_sys_reset_n,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   localparam int CW = starve_cnt_width(STARVE_MAX);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   logic [CW-1:0] starve_cnt;

   // Counter register. Increments stop at CNT_MAX so the flag stays up
   // until port 1 actually receives a grant.
   always_ff @(posedge i_sys_clock) begin
      if (!i_sys_reset_n) begin
         starve_cnt <= '0;
      end else if (clr) begin
         starve_cnt <= '0;
      end else if (inc && !at_max) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign at_max = (starve_cnt == CNT_MAX);

endmodule

// File: rtl/u_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// u_dmem_arbiter
// Two-port arbiter in front of a single-ported data memory with a
// combinational read. Port 0 (CPU MEM stage) normally wins conflicts;
// port 1 (loader/debug) is protected from starvation and may lock the
// memory for a burst. Read data comes back registered one cycle after
// the grant, tagged with the port that issued the read.
//
// Ports
//   i_sys_clock                 in  1   clock, rising edge
//   i_sys_reset_n               in  1   synchronous active-low reset
//   i_u_dmem_arbiter_p0_*       in      port 0: req, addr[32], wdata[32],
//                                       wr, word
//   i_u_dmem_arbiter_p1_*       in      port 1: as port 0 plus lock
//   o_u_dmem_arbiter_p0_gnt     out 1   port 0 accepted this cycle
//   o_u_dmem_arbiter_p1_gnt     out 1   port 1 accepted this cycle
//   o_u_dmem_arbiter_p0_stall   out 1   port 0 requesting but not granted
//   o_u_dmem_arbiter_rdata      out 32  registered read data
//   o_u_dmem_arbiter_rvalid     out 1   rdata valid this cycle
//   o_u_dmem_arbiter_rid        out 1   port the read data belongs to
//   o_u_dmem_arbiter_mem_*      out     addr[32], wdata[32], wr, word
//   i_u_dmem_arbiter_mem_data   in  32  combinational read data
// ---------------------------------------------------------------------------
module u_dmem_arbiter
   import u_dmem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic        i_sys_clock,
   input  logic        i_sys_reset_n,

   input  logic        i_u_dmem_arbiter_p0_req,
   input  logic [31:0] i_u_dmem_arbiter_p0_addr,
   input  logic [31:0] i_u_dmem_arbiter_p0_wdata,
   input  logic        i_u_dmem_arbiter_p0_wr,
   input  logic        i_u_dmem_arbiter_p0_word,

   input  logic        i_u_dmem_arbiter_p1_req,
   input  logic [31:0] i_u_dmem_arbiter_p1_addr,
   input  logic [31:0] i_u_dmem_arbiter_p1_wdata,
   input  logic        i_u_dmem_arbiter_p1_wr,
   input  logic        i_u_dmem_arbiter_p1_word,
   input  logic        i_u_dmem_arbiter_p1_lock,

   output logic        o_u_dmem_arbiter_p0_gnt,
   output logic        o_u_dmem_arbiter_p1_gnt,
   output logic        o_u_dmem_arbiter_p0_stall,

   output logic [31:0] o_u_dmem_arbiter_rdata,
   output logic        o_u_dmem_arbiter_rvalid,
   output logic        o_u_dmem_arbiter_rid,

   output logic [31:0] o_u_dmem_arbiter_mem_addr,
   output logic [31:0] o_u_dmem_arbiter_mem_wdata,
   output logic        o_u_dmem_arbiter_mem_wr,
   output logic        o_u_dmem_arbiter_mem_word,
   input  logic [31:0] i_u_dmem_arbiter_mem_data
);

   arb_state_t state;
   arb_state_t next_state;

   logic gnt0;
   logic gnt1;
   logic starve_at_max;
   logic starve_inc;
   logic read_gnt;

   logic both_req;
   assign both_req = i_u_dmem_arbiter_p0_req && i_u_dmem_arbiter_p1_req;

   // Port 1 loses a conflict: count it toward forcing a grant later.
   assign starve_inc = both_req && gnt0;

   u_dmem_arb_starve #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .i_sys_clock   (i_sys_clock),
      .i_sys_reset_n (i_sys_reset_n),
      .inc           (starve_inc),
      .clr           (gnt1),
      .at_max        (starve_at_max)
   );

   // FSM state register.
   always_ff @(posedge i_sys_clock) begin
      if (!i_sys_reset_n) begin
         state <= ARB;
      end else begin
         state <= next_state;
      end
   end

   // Grant selection and next state. A locked burst continues only while
   // port 1 keeps both req and lock high; the cycle it drops either one is
   // arbitrated as a normal ARB cycle. Any port-1 grant that carries lock
   // (re)enters LOCK1, so the same rule covers entry and continuation.
   // Grants are forced low during reset so nothing reaches the memory.
   always_comb begin
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      next_state = state;
      if (i_sys_reset_n) begin
         if (state == LOCK1 && i_u_dmem_arbiter_p1_req && i_u_dmem_arbiter_p1_lock) begin
            gnt1 = 1'b1;
         end else if (both_req) begin
            if (starve_at_max) begin
               gnt1 = 1'b1;
            end else begin
               gnt0 = 1'b1;
            end
         end else begin
            gnt0 = i_u_dmem_arbiter_p0_req;
            gnt1 = i_u_dmem_arbiter_p1_req;
         end
         next_state = (gnt1 && i_u_dmem_arbiter_p1_lock) ? LOCK1 : ARB;
      end
   end

   assign o_u_dmem_arbiter_p0_gnt   = gnt0;
   assign o_u_dmem_arbiter_p1_gnt   = gnt1;
   assign o_u_dmem_arbiter_p0_stall = i_u_dmem_arbiter_p0_req && !gnt0;

   // Memory-side mux. With no grant the bus is parked: no write, address
   // zero, word-sized access.
   always_comb begin
      o_u_dmem_arbiter_mem_addr  = 32'h0;
      o_u_dmem_arbiter_mem_wdata = 32'h0;
      o_u_dmem_arbiter_mem_wr    = 1'b0;
      o_u_dmem_arbiter_mem_word  = 1'b1;
      if (gnt0) begin
         o_u_dmem_arbiter_mem_addr  = i_u_dmem_arbiter_p0_addr;
         o_u_dmem_arbiter_mem_wdata = i_u_dmem_arbiter_p0_wdata;
         o_u_dmem_arbiter_mem_wr    = i_u_dmem_arbiter_p0_wr;
         o_u_dmem_arbiter_mem_word  = i_u_dmem_arbiter_p0_word;
      end else if (gnt1) begin
         o_u_dmem_arbiter_mem_addr  = i_u_dmem_arbiter_p1_addr;
         o_u_dmem_arbiter_mem_wdata = i_u_dmem_arbiter_p1_wdata;
         o_u_dmem_arbiter_mem_wr    = i_u_dmem_arbiter_p1_wr;
         o_u_dmem_arbiter_mem_word  = i_u_dmem_arbiter_p1_word;
      end
   end

   assign read_gnt = (gnt0 || gnt1) && !o_u_dmem_arbiter_mem_wr;

   // Response register. rdata/rid only load on a granted read so the last
   // read value stays visible while rvalid is low; reset drops any
   // response that was still in flight.
   always_ff @(posedge i_sys_clock) begin
      if (!i_sys_reset_n) begin
         o_u_dmem_arbiter_rvalid <= 1'b0;
         o_u_dmem_arbiter_rid    <= P0;
         o_u_dmem_arbiter_rdata  <= 32'h0;
      end else begin
         o_u_dmem_arbiter_rvalid <= read_gnt;
         if (read_gnt) begin
            o_u_dmem_arbiter_rdata <= i_u_dmem_arbiter_mem_data;
            o_u_dmem_arbiter_rid   <= gnt1 ? P1 : P0;
         end
      end
   end

endmodule

// File: tb/tb_u_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_u_dmem_arbiter
// Self-checking bench for u_dmem_arbiter: directed scenarios followed by a
// randomized run, all compared every cycle against a transaction-level
// reference model of the arbitration and response rules.
// ---------------------------------------------------------------------------
module tb_u_dmem_arbiter;

   localparam int STARVE_MAX = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_req, p0_wr, p0_word;
   logic [31:0] p0_addr, p0_wdata;
   logic        p1_req, p1_wr, p1_word, p1_lock;
   logic [31:0] p1_addr, p1_wdata;
   logic        p0_gnt, p1_gnt, p0_stall;
   logic [31:0] rdata;
   logic        rvalid, rid;
   logic [31:0] mem_addr, mem_wdata, mem_data;
   logic        mem_wr, mem_word;

   int errors = 0;
   int checks = 0;

   // Values observed in the most recent cycle, for directed checks.
   logic obs_g0, obs_g1, obs_stall, obs_mem_wr, obs_mem_word;

   // Reference model state.
   logic [7:0]  ref_mem [0:255] = '{default: 8'h00};
   int          m_starve;
   logic        m_locked;
   logic        m_pend;
   logic        m_rid;
   logic [31:0] m_rdata;

   // Memory seen by the DUT.
   logic [7:0]  env_mem [0:255] = '{default: 8'h00};

   always #5 clk = ~clk;

   u_dmem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .i_sys_clock                (clk),
      .i_sys_reset_n              (rst_n),
      .i_u_dmem_arbiter_p0_req    (p0_req),
      .i_u_dmem_arbiter_p0_addr   (p0_addr),
      .i_u_dmem_arbiter_p0_wdata  (p0_wdata),
      .i_u_dmem_arbiter_p0_wr     (p0_wr),
      .i_u_dmem_arbiter_p0_word   (p0_word),
      .i_u_dmem_arbiter_p1_req    (p1_req),
      .i_u_dmem_arbiter_p1_addr   (p1_addr),
      .i_u_dmem_arbiter_p1_wdata  (p1_wdata),
      .i_u_dmem_arbiter_p1_wr     (p1_wr),
      .i_u_dmem_arbiter_p1_word   (p1_word),
      .i_u_dmem_arbiter_p1_lock   (p1_lock),
      .o_u_dmem_arbiter_p0_gnt    (p0_gnt),
      .o_u_dmem_arbiter_p1_gnt    (p1_gnt),
      .o_u_dmem_arbiter_p0_stall  (p0_stall),
      .o_u_dmem_arbiter_rdata     (rdata),
      .o_u_dmem_arbiter_rvalid    (rvalid),
      .o_u_dmem_arbiter_rid       (rid),
      .o_u_dmem_arbiter_mem_addr  (mem_addr),
      .o_u_dmem_arbiter_mem_wdata (mem_wdata),
      .o_u_dmem_arbiter_mem_wr    (mem_wr),
      .o_u_dmem_arbiter_mem_word  (mem_word),
      .i_u_dmem_arbiter_mem_data  (mem_data)
   );

   // Byte-addressed little-endian memory behind the arbiter; word accesses
   // use the aligned word, byte reads are zero-extended.
   always_comb begin
      mem_data = 32'h0;
      if (mem_word) begin
         mem_data = {env_mem[{mem_addr[7:2], 2'd3}], env_mem[{mem_addr[7:2], 2'd2}],
                     env_mem[{mem_addr[7:2], 2'd1}], env_mem[{mem_addr[7:2], 2'd0}]};
      end else begin
         mem_data = {24'h0, env_mem[mem_addr[7:0]]};
      end
   end

   always @(posedge clk) begin
      if (mem_wr) begin
         if (mem_word) begin
            for (int k = 0; k < 4; k++) env_mem[{mem_addr[7:2], 2'(k)}] <= mem_wdata[8*k +: 8];
         end else begin
            env_mem[mem_addr[7:0]] <= mem_wdata[7:0];
         end
      end
   end

   function automatic logic [31:0] ref_read(input logic [31:0] a, input logic w);
      logic [7:0] b;
      b = {a[7:2], 2'b00};
      if (w) return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
      return {24'h0, ref_mem[a[7:0]]};
   endfunction

   task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic w);
      logic [7:0] b;
      b = {a[7:2], 2'b00};
      if (w) begin
         for (int k = 0; k < 4; k++) ref_mem[b + 8'(k)] = d[8*k +: 8];
      end else begin
         ref_mem[a[7:0]] = d[7:0];
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic rn,
                                input logic r0, input logic [31:0] a0, input logic [31:0] d0,
                                input logic w0, input logic wd0,
                                input logic r1, input logic [31:0] a1, input logic [31:0] d1,
                                input logic w1, input logic wd1, input logic lk1);
      rst_n = rn;
      p0_req = r0; p0_addr = a0; p0_wdata = d0; p0_wr = w0; p0_word = wd0;
      p1_req = r1; p1_addr = a1; p1_wdata = d1; p1_wr = w1; p1_word = wd1; p1_lock = lk1;
   endtask

   // One clock cycle: compare everything against the model mid-cycle, then
   // advance the model at the rising edge.
   task automatic runCycle();
      logic        eg0, eg1, gw, gword;
      logic [31:0] ga, gd;
      @(negedge clk);
      eg0 = 1'b0;
      eg1 = 1'b0;
      if (rst_n) begin
         if (m_locked && p1_req && p1_lock) eg1 = 1'b1;
         else if (p0_req && p1_req) begin
            if (m_starve == STARVE_MAX) eg1 = 1'b1;
            else eg0 = 1'b1;
         end else begin
            eg0 = p0_req;
            eg1 = p1_req;
         end
      end
      ga = eg0 ? p0_addr : (eg1 ? p1_addr : 32'h0);
      gd = eg0 ? p0_wdata : p1_wdata;
      gw = eg0 ? p0_wr : (eg1 ? p1_wr : 1'b0);
      gword = eg0 ? p0_word : (eg1 ? p1_word : 1'b1);

      obs_g0 = p0_gnt; obs_g1 = p1_gnt; obs_stall = p0_stall;
      obs_mem_wr = mem_wr; obs_mem_word = mem_word;

      checkOutput("p0_gnt", {31'h0, p0_gnt}, {31'h0, eg0});
      checkOutput("p1_gnt", {31'h0, p1_gnt}, {31'h0, eg1});
      checkOutput("p0_stall", {31'h0, p0_stall}, {31'h0, p0_req && !eg0});
      checkOutput("mem_addr", mem_addr, ga);
      checkOutput("mem_wr", {31'h0, mem_wr}, {31'h0, gw});
      checkOutput("mem_word", {31'h0, mem_word}, {31'h0, gword});
      if (eg0 || eg1) checkOutput("mem_wdata", mem_wdata, gd);
      checkOutput("rvalid", {31'h0, rvalid}, {31'h0, m_pend});
      checkOutput("rdata", rdata, m_rdata);
      if (m_pend) checkOutput("rid", {31'h0, rid}, {31'h0, m_rid});

      @(posedge clk);
      if (!rst_n) begin
         m_locked = 1'b0; m_starve = 0; m_pend = 1'b0; m_rid = 1'b0; m_rdata = 32'h0;
      end else begin
         m_pend = 1'b0;
         if (eg0 || eg1) begin
            if (gw) ref_write(ga, gd, gword);
            else begin
               m_pend = 1'b1;
               m_rid = eg1;
               m_rdata = ref_read(ga, gword);
            end
         end
         if (eg1) m_starve = 0;
         else if (eg0 && p0_req && p1_req && m_starve < STARVE_MAX) m_starve++;
         m_locked = eg1 && p1_lock;
      end
      #1;
   endtask

   initial begin
      $display("[TB] start");
      applyStimulus(1'b0, 1'b1, 32'h4, 32'h0, 1'b1, 1'b1, 1'b1, 32'h8, 32'h0, 1'b1, 1'b1, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      m_locked = 1'b0; m_starve = 0; m_pend = 1'b0; m_rid = 1'b0; m_rdata = 32'h0;

      // Reset held with both ports requesting: no grant, no write.
      runCycle();
      checkOutput("reset_p0_gnt", {31'h0, obs_g0}, 32'h0);
      checkOutput("reset_p1_gnt", {31'h0, obs_g1}, 32'h0);
      checkOutput("reset_mem_wr", {31'h0, obs_mem_wr}, 32'h0);
      checkOutput("reset_rvalid", {31'h0, rvalid}, 32'h0);
      checkOutput("reset_rid", {31'h0, rid}, 32'h0);
      checkOutput("reset_rdata", rdata, 32'h0);

      // Preload 0xDEADBEEF at 0x10 through port 0, then a solo word read.
      applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      runCycle();
      applyStimulus(1'b1, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      runCycle();
      checkOutput("solo_read_gnt", {31'h0, obs_g0}, 32'h1);
      checkOutput("solo_read_rvalid", {31'h0, rvalid}, 32'h1);
      checkOutput("solo_read_rid", {31'h0, rid}, 32'h0);
      checkOutput("solo_read_rdata", rdata, 32'hDEADBEEF);

      // Byte write then byte read of the same address back to back.
      applyStimulus(1'b1, 1'b1, 32'h3, 32'h000000AB, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      runCycle();
      checkOutput("byte_wr_word", {31'h0, obs_mem_word}, 32'h0);
      checkOutput("byte_wr_rvalid", {31'h0, rvalid}, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h3, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      runCycle();
      checkOutput("byte_rd_word", {31'h0, obs_mem_word}, 32'h0);
      checkOutput("byte_rd_rdata", rdata, 32'h000000AB);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      runCycle();
      checkOutput("idle_rvalid", {31'h0, rvalid}, 32'h0);
      checkOutput("idle_rdata_hold", rdata, 32'h000000AB);

      // Continuous conflict: p0,p0,p0,p1 repeating. Eleven cycles leave
      // the starvation count at its maximum for the locked burst below.
      applyStimulus(1'b1, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 11; i++) begin
         runCycle();
         checkOutput($sformatf("conflict_p1_gnt_%0d", i), {31'h0, obs_g1}, {31'h0, (i % 4) == 3});
         checkOutput($sformatf("conflict_stall_%0d", i), {31'h0, obs_stall}, {31'h0, (i % 4) == 3});
      end

      // Locked burst of five port-1 writes while port 0 keeps requesting.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1,
                       1'b1, 32'h40 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 1'b1, 1'b1, 1'b1);
         runCycle();
         checkOutput($sformatf("lock_p1_gnt_%0d", i), {31'h0, obs_g1}, 32'h1);
         checkOutput($sformatf("lock_stall_%0d", i), {31'h0, obs_stall}, 32'h1);
      end
      applyStimulus(1'b1, 1'b1, 32'h48, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      runCycle();
      checkOutput("lock_exit_p0_gnt", {31'h0, obs_g0}, 32'h1);
      runCycle();
      checkOutput("lock_data_rdata", rdata, 32'hC0DE0002);

      // Reset asserted while in LOCK1 with a read response in flight.
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1);
      runCycle();
      checkOutput("lock_read_p1_gnt", {31'h0, obs_g1}, 32'h1);
      applyStimulus(1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1);
      runCycle();
      checkOutput("mid_reset_p1_gnt", {31'h0, obs_g1}, 32'h0);
      checkOutput("post_reset_rvalid", {31'h0, rvalid}, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1);
      runCycle();
      checkOutput("post_reset_p0_gnt", {31'h0, obs_g0}, 32'h1);
      checkOutput("post_reset_p1_gnt", {31'h0, obs_g1}, 32'h0);

      // Randomized traffic, including occasional resets and locked bursts.
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 39) != 0,
                       1'($urandom), 32'($urandom_range(0, 255)), $urandom, 1'($urandom), 1'($urandom),
                       1'($urandom), 32'($urandom_range(0, 255)), $urandom, 1'($urandom), 1'($urandom),
                       $urandom_range(0, 2) == 0);
         runCycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
